mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 4096; number of 32-bit words in the backing array.
REQ-002 Parameter: LATENCY, default 2, legal range 1..15; cycles from accepted mem_init to mem_ready.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_init  input  1  one-cycle strobe from the initiator starting an access.
REQ-006 mem_read_op  input  3  read op: bit2 is unsigned, bits[1:0] are size (00 none, 01 byte, 10 half, 11 word).
REQ-007 mem_write_op  input  2  write size (00 none, 01 byte, 10 half, 11 word).
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, taken from the LSBs for byte and half stores.
REQ-010 rdata  output  32  load result, extended to 32 bits.
REQ-011 mem_ready  output  1  one-cycle pulse marking access completion.
REQ-012 busy  output  1  high while an accepted access is outstanding.
REQ-013 err  output  1  one-cycle pulse coincident with mem_ready for a faulted access.

Function
REQ-014 The FSM SHALL have two states: IDLE and WAIT.
REQ-015 In IDLE, mem_init=1 SHALL latch mem_read_op, mem_write_op, addr and wdata, and move to WAIT.
REQ-016 In WAIT, mem_init SHALL be ignored.
REQ-017 mem_ready SHALL pulse exactly LATENCY cycles after the accepting edge; at that edge the FSM SHALL return to IDLE.
REQ-018 Back-to-back accesses: mem_init in the cycle after mem_ready SHALL be accepted.
REQ-019 busy SHALL be 1 in WAIT and 0 in IDLE.
REQ-020 Read lane selection: byte from lane addr[1:0]; half from lanes {addr[1],1} and {addr[1],0}; word from all lanes.
REQ-021 Read extension: the result SHALL be sign-extended when bit2=0 and zero-extended when bit2=1.
REQ-022 rdata SHALL update on the mem_ready cycle and hold its value until the next read completes.
REQ-023 Write lanes: a byte store SHALL write wdata[7:0] to lane addr[1:0].
REQ-024 Write lanes: a half store SHALL write wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1.
REQ-025 Write lanes: a word store SHALL write all four lanes.
REQ-026 The write SHALL commit on the mem_ready cycle; other lanes of the word SHALL be unchanged.
REQ-027 If read size and write size are both nonzero, the read SHALL be performed, the write SHALL be dropped, and err SHALL pulse.
REQ-028 An access with read size 00 and write size 00 SHALL still complete with mem_ready.
REQ-029 For that no-op access, rdata SHALL be unchanged and err SHALL stay 0.
REQ-030 Fault conditions: a misaligned half access (addr[0]=1) SHALL fault.
REQ-031 Fault conditions: a misaligned word access (addr[1:0]!=0) SHALL fault.
REQ-032 Fault conditions: an access with addr[31:2] >= DEPTH_WORDS SHALL fault.
REQ-033 A faulted access SHALL make no array write, SHALL set rdata=0 if it is a read, and SHALL still pulse mem_ready together with err.
REQ-034 Word index SHALL be addr[31:2]; there SHALL be no wrap-around.

Reset
REQ-035 On reset assertion, the FSM SHALL immediately enter IDLE with mem_ready=0, err=0, busy=0 and rdata=0.
REQ-036 An access in progress when reset asserts SHALL be abandoned: no write commits and no mem_ready is issued.
REQ-037 The backing array SHALL NOT be cleared by reset.
REQ-038 Latched request registers SHALL reset to 0.

Verification
REQ-039 Word round trip: LATENCY=2, write word 0xDEADBEEF at 0x10, then read word at 0x10 -> rdata=0xDEADBEEF; mem_ready 2 cycles after each init; err=0.
REQ-040 Byte signedness: after the REQ-039 contents, LB at 0x13 -> 0xFFFFFFDE; LBU at 0x13 -> 0x000000DE; LH at 0x12 -> 0xFFFFDEAD; LHU at 0x10 -> 0x0000BEEF.
REQ-041 Partial store: SB 0x55 at 0x11 over 0xDEADBEEF, then read word at 0x10 -> 0xDEAD55EF.
REQ-042 Faults: LW at 0x12 -> mem_ready+err, rdata=0.
REQ-043 Faults: SW at DEPTH_WORDS*4 -> mem_ready+err, array unchanged.
REQ-044 Faults: read+write both set -> read data returned, err=1.
REQ-045 Reset mid-op: assert SW 0x12345678 at 0x20, pulse reset 1 cycle later -> no mem_ready; subsequent LW 0x20 returns the prior contents.
REQ-046 Ignored init and back-to-back: mem_init during WAIT -> no extra mem_ready; init in the cycle after mem_ready -> accepted, busy=1 the next cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory responder: latches one request, completes it LATENCY cycles later
// with byte/half/word lanes, sign/zero extension and alignment/range fault reporting.
module mem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  req_rop;
  logic [1:0]  req_wop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]    rsize, wsize, size;
  logic [29:0]   widx;
  logic [AW-1:0] midx;
  logic          misalign, oob, fault, conflict, done, do_write;
  logic [31:0]   word, rd_val, wd_lanes;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    be;

  always_comb begin
    rsize    = req_rop[1:0];
    wsize    = req_wop;
    // When both sizes are set the read wins, so alignment is judged on the read size.
    size     = (rsize != 2'b00) ? rsize : wsize;
    widx     = req_addr[31:2];
    midx     = widx[AW-1:0];
    misalign = (size == 2'b10 && req_addr[0]) ||
               (size == 2'b11 && req_addr[1:0] != 2'b00);
    oob      = {2'b00, widx} >= 32'(DEPTH_WORDS);
    fault    = (size != 2'b00) && (misalign || oob);
    conflict = (rsize != 2'b00) && (wsize != 2'b00);
    done     = (state == WAIT) && (cnt == 4'd0);
    do_write = done && (wsize != 2'b00) && (rsize == 2'b00) && !fault;

    word    = oob ? 32'd0 : mem[midx];
    rd_byte = word[{req_addr[1:0], 3'b000} +: 8];
    rd_half = req_addr[1] ? word[31:16] : word[15:0];
    rd_val  = 32'd0;
    case (rsize)
      2'b01:   rd_val = req_rop[2] ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b10:   rd_val = req_rop[2] ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      2'b11:   rd_val = word;
      default: rd_val = 32'd0;
    endcase
    if (fault) rd_val = 32'd0;

    be       = 4'b0000;
    wd_lanes = req_wdata;
    case (wsize)
      2'b01: begin
        be       = 4'b0001 << req_addr[1:0];
        wd_lanes = {4{req_wdata[7:0]}};
      end
      2'b10: begin
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{req_wdata[15:0]}};
      end
      2'b11:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array contents survive reset; only the FSM is cleared.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[midx][i*8 +: 8] <= wd_lanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_rop   <= 3'd0;
      req_wop   <= 2'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      rdata     <= 32'd0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_init) begin
            req_rop   <= mem_read_op;
            req_wop   <= mem_write_op;
            req_addr  <= addr;
            req_wdata <= wdata;
            cnt       <= 4'(LATENCY - 1);
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mem_ready <= 1'b1;
            err       <= fault || conflict;
            if (rsize != 2'b00) rdata <= rd_val;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-addressed reference model.
module tb_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_init = 1'b0;
  logic [2:0]  mem_read_op = 3'd0;
  logic [1:0]  mem_write_op = 2'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        mem_ready, busy, err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  model_mem [DEPTH*4];
  logic [31:0] model_rdata = 32'd0;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_init(mem_init), .mem_read_op(mem_read_op),
    .mem_write_op(mem_write_op), .addr(addr), .wdata(wdata), .rdata(rdata),
    .mem_ready(mem_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Byte-addressed model: an access touches bytes a..a+n-1, little-endian.
  task automatic model_access(input logic [2:0] rop, input logic [1:0] wop,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic exp_err, output logic [31:0] exp_rd);
    logic [1:0]  sz;
    int          nb;
    logic        flt;
    logic [31:0] v;
    sz  = (rop[1:0] != 2'b00) ? rop[1:0] : wop;
    nb  = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    flt = (sz != 2'b00) && (((a % nb) != 0) || ((a / 4) >= DEPTH));
    exp_err = flt || ((rop[1:0] != 2'b00) && (wop != 2'b00));
    if (rop[1:0] != 2'b00) begin
      v = 32'd0;
      if (!flt) begin
        for (int i = 0; i < nb; i++) v = v | (32'(model_mem[a + i]) << (8 * i));
        if (!rop[2] && nb < 4 && v[8*nb-1])
          for (int i = nb; i < 4; i++) v = v | (32'hFF << (8 * i));
      end
      model_rdata = v;
    end else if (wop != 2'b00 && !flt) begin
      for (int i = 0; i < nb; i++) model_mem[a + i] = wd[8*i +: 8];
    end
    exp_rd = model_rdata;
  endtask

  task automatic access(input string tag, input logic [2:0] rop, input logic [1:0] wop,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic        e;
    logic [31:0] r;
    int          cyc;
    model_access(rop, wop, a, wd, e, r);
    @(negedge clk);
    mem_init = 1'b1; mem_read_op = rop; mem_write_op = wop; addr = a; wdata = wd;
    @(posedge clk); #1;
    if (hold) begin
      // Stray request during WAIT: would clobber word 0 if it were accepted.
      mem_read_op = 3'd0; mem_write_op = 2'b11; addr = 32'd0; wdata = 32'hBAD0BAD0;
    end else begin
      mem_init = 1'b0;
    end
    check({tag, ":busy_wait"}, busy, 1);
    check({tag, ":early_ready"}, mem_ready, 0);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
      mem_init = 1'b0;
    end while (!mem_ready && cyc < LAT + 8);
    check({tag, ":latency"}, cyc, LAT);
    check({tag, ":err"}, err, e);
    check({tag, ":rdata"}, rdata, r);
    check({tag, ":busy_done"}, busy, 0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [1:0]  wop;
    logic [31:0] a;
    bit          seen;

    #2 reset = 1'b1;
    #1;
    check("rst:busy", busy, 0);
    check("rst:ready", mem_ready, 0);
    check("rst:err", err, 0);
    check("rst:rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) access("fill", 3'd0, 2'b11, 32'(w * 4), $urandom, 0);

    access("sw10", 3'd0, 2'b11, 32'h10, 32'hDEADBEEF, 0);
    access("lw10", 3'b011, 2'd0, 32'h10, 32'd0, 0);
    check("lw10_lit", rdata, 32'hDEADBEEF);
    access("lb13", 3'b001, 2'd0, 32'h13, 32'd0, 0);
    check("lb13_lit", rdata, 32'hFFFFFFDE);
    access("lbu13", 3'b101, 2'd0, 32'h13, 32'd0, 0);
    check("lbu13_lit", rdata, 32'h000000DE);
    access("lh12", 3'b010, 2'd0, 32'h12, 32'd0, 0);
    check("lh12_lit", rdata, 32'hFFFFDEAD);
    access("lhu10", 3'b110, 2'd0, 32'h10, 32'd0, 0);
    check("lhu10_lit", rdata, 32'h0000BEEF);
    access("sb11", 3'd0, 2'b01, 32'h11, 32'h00000055, 0);
    access("lw10b", 3'b011, 2'd0, 32'h10, 32'd0, 0);
    check("sb_lit", rdata, 32'hDEAD55EF);
    access("lw12_mis", 3'b011, 2'd0, 32'h12, 32'd0, 0);
    check("lw12_lit", {rdata[31:1], err}, 32'h1);
    access("sw_oob", 3'd0, 2'b11, 32'(DEPTH * 4), 32'hCAFEF00D, 0);
    access("lw0_after_oob", 3'b011, 2'd0, 32'h0, 32'd0, 0);
    access("conflict", 3'b011, 2'b11, 32'h10, 32'h11111111, 0);
    check("conflict_lit", rdata, 32'hDEAD55EF);
    access("lw10_after_conf", 3'b011, 2'd0, 32'h10, 32'd0, 0);
    access("noop", 3'b100, 2'd0, 32'h10, 32'd0, 0);
    access("lh11_mis", 3'b010, 2'd0, 32'h11, 32'd0, 0);
    access("sh13_mis", 3'd0, 2'b10, 32'h13, 32'hFFFF, 0);
    access("sh12", 3'd0, 2'b10, 32'h12, 32'h0000A5A5, 0);
    access("ignored_init", 3'b011, 2'd0, 32'h10, 32'd0, 1);
    @(posedge clk); #1;
    check("no_extra_ready", mem_ready, 0);
    access("lw0_after_ign", 3'b011, 2'd0, 32'h0, 32'd0, 0);

    // Reset while a store is outstanding: the store must never land.
    @(negedge clk);
    mem_init = 1'b1; mem_read_op = 3'd0; mem_write_op = 2'b11; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1 mem_init = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("midrst:busy", busy, 0);
    check("midrst:rdata", rdata, 0);
    model_rdata = 32'd0;
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready) seen = 1'b1;
    end
    check("midrst:no_ready", seen, 0);
    access("lw20_after_rst", 3'b011, 2'd0, 32'h20, 32'd0, 0);

    for (int k = 0; k < 400; k++) begin
      rop = 3'($urandom_range(0, 7));
      wop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) == 1) rop[1:0] = 2'b00;
        else wop = 2'b00;
      end
      a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 64));
      access("rnd", rop, wop, a, $urandom, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
